// File: rtl/grant_pkg.sv
// grant_pkg: shared definitions for the grant issue stage.
//   state_t          issue FSM state encoding (IDLE / BUSY / SETTLE)
//   DEF_CHANNELS     default number of requestors
//   DEF_MAX_HOLD     default maximum hold time in cycles
//   idx_w()          width of a binary index into an N-bit vector
package grant_pkg;

  localparam int unsigned DEF_CHANNELS = 8;
  localparam int unsigned DEF_MAX_HOLD = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // At least one bit so a single-channel build still has a legal index port.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/grant_issue_lsb_pick.sv
// lsb_pick: combinational lowest-set-bit picker.
// Ports:
//   i_vec     CHANNELS-bit input vector
//   o_onehot  one-hot vector of the lowest set bit of i_vec (0 if none)
//   o_idx     binary index of that bit (0 if none)
//   o_any     high when i_vec has any bit set
module lsb_pick
  import grant_pkg::*;
#(
  parameter  int unsigned CHANNELS = DEF_CHANNELS,
  localparam int unsigned IW       = idx_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] i_vec,
  output logic [CHANNELS-1:0] o_onehot,
  output logic [IW-1:0]       o_idx,
  output logic                o_any
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_onehot = i_vec & (~i_vec + CHANNELS'(1));
  assign o_any    = |i_vec;

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IW'(i);
    end
  end

endmodule

// File: rtl/grant_issue.sv
// grant_issue: issues one grant at a time from a precalculated candidate
// vector, holds it while the owner keeps requesting, and steps through a
// one-cycle settle before the next issue so the precalc stage sees the new
// grant. All outputs are registered.
// Optional feature macro: GRANT_HOLD_TIMEOUT_EN adds a hold counter that
// removes an owner after MAX_HOLD cycles and pulses preempt.
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   request     live request vector
//   nextGrant   registered candidate vector from the precalc stage
//   grant       one-hot last-issued grant (held after release)
//   grantValid  high while the owner holds the resource
//   grantId     binary index of grant
//   preempt     one-cycle pulse when an owner is removed by timeout
//
// state  | meaning
// IDLE   | no owner; issue on the first non-zero candidate vector
// BUSY   | owner holds the grant until release (or timeout)
// SETTLE | one cycle for nextGrant to catch up with the new grant
module grant_issue
  import grant_pkg::*;
#(
  parameter  int unsigned CHANNELS = DEF_CHANNELS,
  parameter  int unsigned MAX_HOLD = DEF_MAX_HOLD,
  localparam int unsigned IW       = idx_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] request,
  input  logic [CHANNELS-1:0] nextGrant,
  output logic [CHANNELS-1:0] grant,
  output logic                grantValid,
  output logic [IW-1:0]       grantId,
  output logic                preempt
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CHANNELS-1:0] w_pick_onehot;
  logic [IW-1:0]       w_pick_idx;
  logic                w_pick_any;
  logic                w_owner_req;
  logic                w_timeout;
  logic [CHANNELS-1:0] w_grant_nxt;
  logic [IW-1:0]       w_id_nxt;
  logic                w_valid_nxt;
  logic                w_preempt_nxt;

  lsb_pick #(.CHANNELS(CHANNELS)) u_pick (
    .i_vec    (nextGrant & request),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_owner_req = request[grantId];

`ifdef GRANT_HOLD_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  assign w_timeout = (r_cnt == 8'd0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state == ST_IDLE && w_pick_any)                   w_cnt_nxt = 8'(MAX_HOLD - 1);
    else if (r_state == ST_BUSY && w_owner_req && !w_timeout) w_cnt_nxt = r_cnt - 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end
`else
  // MAX_HOLD has no effect when the timeout is compiled out.
  logic w_unused_max_hold;
  assign w_unused_max_hold = ^8'(MAX_HOLD);
  assign w_timeout         = 1'b0;
`endif

  // State register plus the registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      grant      <= '0;
      grantId    <= '0;
      grantValid <= 1'b0;
      preempt    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      grant      <= w_grant_nxt;
      grantId    <= w_id_nxt;
      grantValid <= w_valid_nxt;
      preempt    <= w_preempt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_state_nxt = w_pick_any ? ST_BUSY : ST_IDLE;
      ST_BUSY:   w_state_nxt = (!w_owner_req || w_timeout) ? ST_SETTLE : ST_BUSY;
      ST_SETTLE: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // grant/grantId keep the last owner unless a new issue happens, so the
  // precalc stage can rotate from it.
  always_comb begin
    w_grant_nxt   = grant;
    w_id_nxt      = grantId;
    w_valid_nxt   = 1'b0;
    w_preempt_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_onehot;
          w_id_nxt    = w_pick_idx;
          w_valid_nxt = 1'b1;
        end
      end
      ST_BUSY: begin
        // Release wins over a coincident timeout: no preempt pulse then.
        if (w_owner_req) begin
          w_valid_nxt   = !w_timeout;
          w_preempt_nxt = w_timeout;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_grant_issue.sv
module tb_grant_issue;

  localparam int CH   = 8;
  localparam int HOLD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] request;
  logic [CH-1:0] nextGrant;
  logic [CH-1:0] grant;
  logic          grantValid;
  logic [2:0]    grantId;
  logic          preempt;

  int n_chk = 0;
  int n_bad = 0;

`ifdef GRANT_HOLD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  grant_issue #(.CHANNELS(CH), .MAX_HOLD(HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .request    (request),
    .nextGrant  (nextGrant),
    .grant      (grant),
    .grantValid (grantValid),
    .grantId    (grantId),
    .preempt    (preempt)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the resource, for how long, and whether the
  // one settle cycle is pending.
  int       m_owner;
  bit       m_busy;
  bit       m_settle;
  int       m_held;
  bit [7:0] m_grant;
  bit       m_valid;
  bit       m_pre;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_busy = 0; m_settle = 0; m_held = 0;
    m_grant = '0; m_valid = 0; m_pre = 0;
  endtask

  task automatic model_edge(input bit [7:0] req, input bit [7:0] ng);
    bit [7:0] cand;
    m_pre = 0;
    if (m_settle) begin
      m_settle = 0;
      m_valid  = 0;
    end else if (m_busy) begin
      if (!req[m_owner]) begin
        m_busy = 0; m_settle = 1; m_valid = 0;
      end else if (TMO_EN && m_held >= HOLD) begin
        m_busy = 0; m_settle = 1; m_valid = 0; m_pre = 1;
      end else begin
        m_held++;
      end
    end else begin
      cand = req & ng;
      m_valid = 0;
      for (int i = 0; i < CH; i++) begin
        if (cand[i] && !m_valid) begin
          m_owner = i;
          m_grant = 8'(1 << i);
          m_busy  = 1;
          m_valid = 1;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".grant"},   32'(grant),      32'(m_grant));
    chk({tag, ".valid"},   32'(grantValid), 32'(m_valid));
    chk({tag, ".id"},      32'(grantId),    32'(m_owner));
    chk({tag, ".preempt"}, 32'(preempt),    32'(m_pre));
  endtask

  task automatic step(input string tag, input bit [7:0] req, input bit [7:0] ng);
    request   = req;
    nextGrant = ng;
    @(posedge clk);
    model_edge(req, ng);
    #1;
    check_all(tag);
  endtask

  initial begin
    bit [7:0] r, n;
    reset = 1'b1; request = '0; nextGrant = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.grant",   32'(grant),      32'h0);
    chk("rst.valid",   32'(grantValid), 32'h0);
    chk("rst.preempt", 32'(preempt),    32'h0);
    chk("rst.id",      32'(grantId),    32'h0);
    reset = 1'b0;

    // No candidate: nothing issues.
    step("idle0", 8'h05, 8'h00);
    step("idle1", 8'h00, 8'h05);

    // Basic issue, release, settle, next issue.
    step("issue0", 8'h05, 8'h05);
    chk("issue0.exp_grant", 32'(grant), 32'h01);
    chk("issue0.exp_valid", 32'(grantValid), 32'h1);
    step("rel0", 8'h04, 8'h00);
    chk("rel0.exp_valid", 32'(grantValid), 32'h0);
    chk("rel0.exp_grant", 32'(grant), 32'h01);
    step("settle0", 8'h04, 8'h04);
    chk("settle0.exp_valid", 32'(grantValid), 32'h0);
    step("issue2", 8'h04, 8'h04);
    chk("issue2.exp_grant", 32'(grant), 32'h04);
    chk("issue2.exp_id", 32'(grantId), 32'd2);
    step("rel2", 8'h00, 8'h00);
    step("settle2", 8'h00, 8'h00);

    // Hold request[3].
    step("hold.issue", 8'h08, 8'h08);
    for (int k = 1; k < HOLD; k++) begin
      step("hold.busy", 8'h08, 8'h00);
      chk("hold.busy_valid", 32'(grantValid), 32'h1);
    end
    step("hold.end", 8'h08, 8'h00);
    chk("hold.end_valid",   32'(grantValid), TMO_EN ? 32'h0 : 32'h1);
    chk("hold.end_preempt", 32'(preempt),    TMO_EN ? 32'h1 : 32'h0);
    step("hold.after", 8'h08, 8'h00);
    chk("hold.after_preempt", 32'(preempt), 32'h0);
    step("hold.drop", 8'h00, 8'h00);
    step("hold.drop2", 8'h00, 8'h00);
    step("hold.drop3", 8'h00, 8'h00);

    // Wrap from channel 7 to channel 1.
    step("wrap.issue7", 8'h80, 8'h80);
    step("wrap.rel", 8'h00, 8'h00);
    step("wrap.settle", 8'h00, 8'h00);
    step("wrap.issue1", 8'h02, 8'h02);
    chk("wrap.exp_grant", 32'(grant), 32'h02);
    chk("wrap.exp_id", 32'(grantId), 32'd1);
    step("wrap.drop", 8'h00, 8'h00);
    step("wrap.drop2", 8'h00, 8'h00);

    // Multi-hot nextGrant, with the lowest nextGrant bit not requesting.
    step("multi", 8'h0C, 8'h0E);
    chk("multi.exp_id", 32'(grantId), 32'd2);
    step("multi.drop", 8'h00, 8'h00);
    step("multi.drop2", 8'h00, 8'h00);

    // Asynchronous reset mid-BUSY.
    step("mid.issue", 8'h10, 8'h10);
    step("mid.busy", 8'h10, 8'h00);
    #3 reset = 1'b1;
    #1;
    model_reset();
    chk("mid.grant",   32'(grant),      32'h0);
    chk("mid.valid",   32'(grantValid), 32'h0);
    chk("mid.id",      32'(grantId),    32'h0);
    chk("mid.preempt", 32'(preempt),    32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("mid.idle", 8'h10, 8'h00);
    step("mid.reissue", 8'h10, 8'h10);
    chk("mid.reissue_grant", 32'(grant), 32'h10);
    step("mid.drop", 8'h00, 8'h00);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      r = 8'($urandom);
      n = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if (m_busy && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
      step("rand", r, n);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/grant_issue.md
GRANT_ISSUE -- requirements
Module: grant_issue

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, giving the number of requestors.
REQ-002 SHALL have parameter MAX_HOLD, default 16, giving the maximum cycles an owner keeps a grant (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock, rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: the system reset, asynchronous and active-high.
REQ-005 SHALL have port request, input, CHANNELS bits: live request vector.
REQ-006 SHALL have port nextGrant, input, CHANNELS bits: registered precalculated candidate vector from the next-grant precalc stage.
REQ-007 SHALL have port grant, output, CHANNELS bits: registered one-hot last-issued grant, fed back to the precalc stage.
REQ-008 SHALL have port grantValid, output, 1 bit: high while the grant owner holds the resource.
REQ-009 SHALL have port grantId, output, clog2(CHANNELS) bits: binary index of grant.
REQ-010 SHALL have port preempt, output, 1 bit: one-cycle pulse when an owner is removed by timeout.

Function
REQ-011 SHALL implement states IDLE, BUSY and SETTLE, with all outputs registered.
REQ-012 In IDLE, when the candidate vector (nextGrant AND request) is non-zero, SHALL load grant with its lowest set bit, load grantId, set grantValid=1, load the hold counter with MAX_HOLD-1 and go to BUSY on that edge (1-cycle latency).
REQ-013 In IDLE with a zero candidate vector, SHALL stay in IDLE, leaving grant and grantId unchanged and grantValid=0.
REQ-014 In BUSY, when request[grantId]==0, SHALL clear grantValid and go to SETTLE.
REQ-015 In BUSY, with the owner still requesting and the counter at 0, SHALL clear grantValid, pulse preempt for exactly 1 cycle and go to SETTLE; otherwise it SHALL decrement the counter.
REQ-016 When release and timeout occur in the same cycle, SHALL treat the event as a release with no preempt pulse.
REQ-017 SETTLE SHALL last exactly 1 cycle, then go to IDLE, so that nextGrant reflects the current grant.
REQ-018 grant and grantId SHALL hold the last owner after release or preempt, so that round-robin rotation is preserved; only a new issue or reset changes them.
REQ-019 A multi-hot nextGrant SHALL resolve to the lowest index; a nextGrant bit whose request bit is low SHALL be ignored.
REQ-020 The unreachable state encoding SHALL go to IDLE with grantValid=0.

Reset
REQ-021 On reset assertion, SHALL asynchronously set state=IDLE, grant=0, grantId=0, grantValid=0, preempt=0 and counter=0, including when reset asserts mid-BUSY.
REQ-022 After reset deassertion, the first issue SHALL occur no earlier than the first edge at which the candidate vector is non-zero.

Configuration
REQ-023 Macro GRANT_HOLD_TIMEOUT_EN SHALL, when defined, compile in the hold counter and the REQ-015 preemption.
REQ-024 Without GRANT_HOLD_TIMEOUT_EN, SHALL omit the counter, hold the owner until it releases, tie preempt to 0, and ignore MAX_HOLD.

Structure
REQ-025 Package grant_pkg SHALL hold the state enumeration, the default CHANNELS/MAX_HOLD constants and the index-width function.
REQ-026 Sub-module lsb_pick SHALL be a combinational picker producing the one-hot lowest-set-bit vector and its binary index from a CHANNELS-bit vector.

Verification (CHANNELS=8, MAX_HOLD=4)
REQ-027 Reset with request=0 -> grant=0, grantValid=0, preempt=0, state IDLE.
REQ-028 IDLE, request=nextGrant=00000101 -> next edge: grant=00000001, grantId=0, grantValid=1.
REQ-029 Owner drops request[0] -> next edge: grantValid=0 with grant still 00000001; one SETTLE cycle; then nextGrant=request=00000100 -> grant=00000100, grantId=2.
REQ-030 request[3] held, macro defined -> grantValid drops after 4 BUSY cycles with a 1-cycle preempt pulse; macro undefined -> grantValid stays high and preempt=0.
REQ-031 Wrap: grant=10000000, nextGrant=request=00000010 -> grant=00000010, grantId=1.
REQ-032 Reset pulse mid-BUSY -> all outputs 0 without waiting for a clock edge; after release, IDLE.
